// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule constants, state encoding and word helpers.
package aes_pkg;

    localparam int AES_NUM_ROUNDS = 10;

    // RCON[0] occupies the most significant byte.
    localparam logic [79:0] RCON_TABLE = 80'h01_02_04_08_10_20_40_80_1b_36;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        GEN  = 1'b1
    } state_e;

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        int idx;
        idx = int'(rnd);
        if (idx < 10) begin
            return RCON_TABLE[8*(9-idx) +: 8];
        end
        return 8'h00;
    endfunction

endpackage

// File: rtl/aes_key_expand_sbox.sv
// AES forward S-box: multiplicative inverse in GF(2^8) followed by the affine map.
module SBox (
    input  logic [7:0] byte_i,
    output logic [7:0] byte_o
);

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // x^254 == x^-1 for nonzero x, and maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = x;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    logic [7:0] inv;

    assign inv    = gf_inv(byte_i);
    assign byte_o = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                        ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;

endmodule

// File: rtl/aes_key_expand.sv
// AES-128 key schedule: streams round keys 0..10 for one accepted cipher key.
// state | meaning:  IDLE | waiting for key_valid ;  GEN | presenting rk_round/rk_out
module aes_key_expand
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = AES_NUM_ROUNDS
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         key_valid,
    output logic         key_ready,
    input  logic [127:0] key_in,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] rk_out,
    output logic [3:0]   rk_round,
    output logic         busy
);

    state_e       state_q;
    logic [127:0] key_q;
    logic [127:0] key_d;
    logic [3:0]   round_q;
    logic [31:0]  rot_w3;
    logic [31:0]  sub_w3;
    logic [31:0]  t_word;
    logic [31:0]  w0_d, w1_d, w2_d, w3_d;

    assign rot_w3 = rot_word(key_q[31:0]);

    for (genvar b = 0; b < 4; b++) begin : g_subword
        SBox u_sbox (
            .byte_i (rot_w3[8*b +: 8]),
            .byte_o (sub_w3[8*b +: 8])
        );
    end

    assign t_word = sub_w3 ^ {rcon(round_q), 24'h0};
    assign w0_d   = key_q[127:96] ^ t_word;
    assign w1_d   = key_q[95:64]  ^ w0_d;
    assign w2_d   = key_q[63:32]  ^ w1_d;
    assign w3_d   = key_q[31:0]   ^ w2_d;
    assign key_d  = {w0_d, w1_d, w2_d, w3_d};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            key_q   <= '0;
            round_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (key_valid) begin
                        key_q   <= key_in;
                        round_q <= '0;
                        state_q <= GEN;
                    end
                end
                GEN: begin
                    if (rk_ready) begin
                        // Last round key stays on rk_out after returning to IDLE.
                        if (round_q == NUM_ROUNDS[3:0]) begin
                            state_q <= IDLE;
                            round_q <= '0;
                        end else begin
                            key_q   <= key_d;
                            round_q <= round_q + 4'd1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign key_ready = (state_q == IDLE);
    assign rk_valid  = (state_q == GEN);
    assign busy      = (state_q == GEN);
    assign rk_out    = key_q;
    assign rk_round  = round_q;

endmodule

// File: tb/tb_aes_key_expand.sv
// Directed bench for aes_key_expand with a reference key-schedule model and scoreboard.
module tb_aes_key_expand;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         key_valid = 1'b0;
    logic         key_ready;
    logic [127:0] key_in = '0;
    logic         rk_valid;
    logic         rk_ready = 1'b0;
    logic [127:0] rk_out;
    logic [3:0]   rk_round;
    logic         busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]   rnd;
        logic [127:0] key;
    } exp_t;

    exp_t         sb[$];
    logic [127:0] sched  [0:10];
    logic [127:0] obs_rk [0:10];
    logic [127:0] ref_rk [0:10];
    bit           mon_en = 1'b0;
    bit           prev_stall = 1'b0;
    logic [3:0]   prev_round = '0;
    logic [127:0] prev_out = '0;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    always #5 clk = ~clk;

    aes_key_expand dut (
        .clk       (clk),
        .reset     (reset),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key_in    (key_in),
        .rk_valid  (rk_valid),
        .rk_ready  (rk_ready),
        .rk_out    (rk_out),
        .rk_round  (rk_round),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] xt(input logic [7:0] a);
        return a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = xt(x);
        end
        return p;
    endfunction

    // Inverse found by exhaustive search, affine map applied bit by bit.
    function automatic logic [7:0] sbox_ref(input logic [7:0] v);
        logic [7:0] inv = 8'h00;
        logic [7:0] s;
        for (int c = 1; c < 256; c++)
            if (gmul(v, 8'(c)) == 8'h01) inv = 8'(c);
        for (int i = 0; i < 8; i++)
            s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8];
        return s ^ 8'h63;
    endfunction

    task automatic build_schedule(input logic [127:0] key);
        logic [31:0] a, b, c, d, t;
        logic [7:0]  rc = 8'h01;
        sched[0] = key;
        for (int r = 1; r <= 10; r++) begin
            {a, b, c, d} = sched[r-1];
            t = {sbox_ref(d[23:16]), sbox_ref(d[15:8]), sbox_ref(d[7:0]), sbox_ref(d[31:24])};
            t[31:24] ^= rc;
            rc = xt(rc);
            a ^= t;
            b ^= a;
            c ^= b;
            d ^= c;
            sched[r] = {a, b, c, d};
        end
    endtask

    task automatic push_schedule(input logic [127:0] key);
        build_schedule(key);
        for (int r = 0; r <= 10; r++) sb.push_back('{4'(r), sched[r]});
    endtask

    task automatic run_key(input logic [127:0] key, input int ready_pct, input bit inject,
                           output int cycles);
        push_schedule(key);
        key_in    = key;
        key_valid = 1'b1;
        rk_ready  = 1'b1;
        tick();
        key_valid = 1'b0;
        key_in    = {$urandom, $urandom, $urandom, $urandom};
        chk("state_after_accept", {busy, rk_valid, key_ready}, 3'b110);
        cycles = 0;
        while (sb.size() != 0 && cycles < 400) begin
            rk_ready = ($urandom_range(99) < ready_pct);
            if (inject && cycles == 3) begin
                key_valid = 1'b1;
                key_in    = ~key;
                chk("key_ready_low_in_gen", key_ready, 1'b0);
            end else begin
                key_valid = 1'b0;
            end
            tick();
            cycles++;
        end
        key_valid = 1'b0;
        rk_ready  = 1'b0;
        if (sb.size() != 0) begin
            chk("expansion_timeout", sb.size(), 0);
            sb.delete();
        end
        chk("idle_after_r10", {key_ready, rk_valid, busy, rk_round}, {1'b1, 1'b0, 1'b0, 4'd0});
        chk("rk_out_holds_r10", rk_out, sched[10]);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            chk("key_ready_vs_valid", key_ready, !rk_valid);
            chk("busy_vs_valid", busy, rk_valid);
            if (prev_stall)
                chk("stall_hold", {rk_valid, rk_round, rk_out}, {1'b1, prev_round, prev_out});
            if (rk_valid === 1'b1 && sb.size() == 0) begin
                chk("unexpected_rk_valid", rk_valid, 1'b0);
            end else if (rk_valid === 1'b1 && rk_ready === 1'b1) begin
                e = sb.pop_front();
                chk("rk_round", rk_round, e.rnd);
                chk("rk_out", rk_out, e.key);
                obs_rk[e.rnd] = rk_out;
            end
            prev_stall = (rk_valid === 1'b1 && rk_ready === 1'b0);
            prev_round = rk_round;
            prev_out   = rk_out;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cyc;
        reset = 1'b1;
        tick();
        tick();
        chk("reset_flags", {key_ready, rk_valid, busy}, 3'b100);
        chk("reset_rk_round", rk_round, 4'd0);
        chk("reset_rk_out", rk_out, 128'h0);
        reset  = 1'b0;
        mon_en = 1'b1;
        tick();

        run_key(FIPS_KEY, 100, 1'b0, cyc);
        chk("fips_consecutive_cycles", cyc, 11);
        chk("fips_r0", obs_rk[0], FIPS_KEY);
        chk("fips_r1", obs_rk[1], 128'ha0fafe1788542cb123a339392a6c7605);
        chk("fips_r10", obs_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        ref_rk = obs_rk;
        tick();

        run_key(FIPS_KEY, 50, 1'b0, cyc);
        for (int r = 0; r <= 10; r++) chk("stalled_vs_unstalled", obs_rk[r], ref_rk[r]);
        tick();

        run_key(FIPS_KEY, 100, 1'b1, cyc);
        chk("inject_cycles", cyc, 11);
        for (int r = 0; r <= 10; r++) chk("inject_sequence", obs_rk[r], ref_rk[r]);

        run_key(128'h0, 100, 1'b0, cyc);
        chk("zero_r1", obs_rk[1], 128'h62636363626363636263636362636363);
        chk("zero_r10", obs_rk[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
        tick();

        push_schedule(FIPS_KEY);
        key_in    = FIPS_KEY;
        key_valid = 1'b1;
        rk_ready  = 1'b1;
        tick();
        key_valid = 1'b0;
        repeat (5) tick();
        chk("pre_reset_round", rk_round, 4'd5);
        reset     = 1'b1;
        key_valid = 1'b1;
        key_in    = ~FIPS_KEY;
        tick();
        sb.delete();
        chk("reset_mid_flags", {rk_valid, key_ready, busy, rk_round}, {1'b0, 1'b1, 1'b0, 4'd0});
        chk("reset_mid_rk_out", rk_out, 128'h0);
        reset     = 1'b0;
        key_valid = 1'b0;
        repeat (4) tick();
        chk("idle_after_reset", rk_valid, 1'b0);

        run_key({$urandom, $urandom, $urandom, $urandom}, 70, 1'b0, cyc);
        run_key(FIPS_KEY, 100, 1'b0, cyc);
        chk("post_reset_fips_r10", obs_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_key_expand.md
# aes_key_expand

AES-128 key-schedule generator that expands one 128-bit cipher key into the 11 round keys, round 0 through round 10, emitting one round key per cycle over a valid/ready stream. It sits directly downstream of the SBox lookup block and instantiates it four times to compute SubWord on the rotated last word. The round keys feed the AddRoundKey path of the cipher datapath.

## Interface
- `NUM_ROUNDS`, default 10: last round index emitted. Fixed at 10 for AES-128; other values are unsupported.
- `clk` input 1: system clock; all state changes on its rising edge.
- `reset` input 1: synchronous, active-high reset.
- `key_valid` input 1: `key_in` is valid.
- `key_ready` output 1: block can accept a key. High only in IDLE.
- `key_in` input 128: cipher key. Word w0 = `key_in[127:96]`, w3 = `key_in[31:0]`.
- `rk_valid` output 1: `rk_out` and `rk_round` are valid.
- `rk_ready` input 1: consumer accepts the current round key.
- `rk_out` output 128: round key, packed in the same word order as `key_in`.
- `rk_round` output 4: index of the round key on `rk_out`, 0..10.
- `busy` output 1: a key expansion is in progress (state GEN).

## Operation
- States:
  - IDLE: `key_ready`=1, `rk_valid`=0.
  - GEN: `key_ready`=0, `rk_valid`=1.
- IDLE -> GEN on `key_valid && key_ready`.
  - Register `key_in` into the key register (`rk_out`).
  - Set `rk_round` = 0.
- In GEN, on handshake `rk_valid && rk_ready`:
  - If `rk_round` == 10: go to IDLE and clear `rk_round` to 0. `rk_out` holds its last value.
  - Otherwise load the next key and increment `rk_round`.
- Next-key arithmetic, with current words w0..w3:
  - t = SubWord(RotWord(w3)) ^ {RCON[rk_round], 24'h0}.
  - RotWord({b0,b1,b2,b3}) = {b1,b2,b3,b0}, where b0 is the MSB byte.
  - SubWord applies SBox to each byte.
  - w0' = w0^t, w1' = w1^w0', w2' = w2^w1', w3' = w3^w2'.
  - All operations are XOR on 32-bit words; no carries.
- RCON[0..9] = 01,02,04,08,10,20,40,80,1b,36.
- Stall: while `rk_valid && !rk_ready`, `rk_out` and `rk_round` are held stable.
- `key_valid` while not in IDLE is ignored; the key is not captured.
- `key_in` is sampled only on the accept edge and may change afterwards.

## Timing
- Reset values: state IDLE, `key_ready`=1, `rk_valid`=0, `busy`=0, `rk_round`=0, `rk_out`=128'h0.
- Key accepted at edge N: round key 0 is valid after edge N (`rk_valid`=1).
- With `rk_ready` held high, round keys 0..10 appear on 11 consecutive cycles. `key_ready` rises the cycle after the round-10 handshake.
- Keys are not overlapped: there is at least one IDLE cycle between the round-10 handshake and the next accepted key.
- SubWord/RCON path is combinational from the registered w3 to the register D input. It is one SBox level plus XORs per cycle.
- `reset` asserted mid-expansion: the next edge returns to the reset values. The partial sequence is dropped and no further `rk_valid` occurs.
- `reset` has priority over a simultaneous `key_valid` or `rk_ready`.

## Structure
- Shared package `aes_pkg` holds:
  - `AES_NUM_ROUNDS` (10).
  - The RCON constant table.
  - The state enum {IDLE, GEN}.
  - A `rot_word` function.
- Four instances of the existing `SBox` form SubWord. No other sub-module is needed.
- Registers: 128-bit key, 4-bit round counter, 1-bit state.

## Test plan
- Reset, then `key_valid`=1 with key 2b7e151628aed2a6abf7158809cf4f3c and `rk_ready`=1:
  - round 0 = the key itself;
  - round 1 = a0fafe1788542cb123a339392a6c7605;
  - round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6;
  - `rk_round` steps 0..10 on 11 consecutive cycles.
- All-zero key, `rk_ready`=1:
  - round 1 = 62636363626363636263636362636363;
  - round 10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- Random `rk_ready` backpressure (about 50%) on the FIPS-197 key:
  - `rk_out` and `rk_round` stay stable while stalled;
  - the 11 keys match the unstalled run exactly.
- `key_valid` pulsed with a different key during GEN:
  - it is ignored, `key_ready` stays 0, and the output sequence is unchanged;
  - a new key is accepted only after returning to IDLE.
- `reset` asserted at round 5:
  - next cycle `rk_valid`=0, `rk_out`=0, `key_ready`=1;
  - a subsequent key expands correctly from round 0.
